taxi_led_status_ctrl: RTL

//  Parametrised board status-LED controller for CH_CNT network ports plus a heartbeat LED.
//  Per port: solid link LED, activity blink and fault flash.

---
 rtl/taxi_led_status_pkg.sv | 22 ++
 rtl/taxi_led_status_ctrl_if.sv | 25 ++
 rtl/taxi_led_status_ch.sv | 100 ++++++++++
 rtl/taxi_led_status_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/taxi_led_status_pkg.sv
// Shared types and elaboration helpers for the board status-LED controller.
package taxi_led_status_pkg;

    typedef enum logic [2:0] {
        ST_DOWN,
        ST_UP,
        ST_ACT_OFF,
        ST_ACT_ON,
        ST_FAULT
    } ch_state_t;

    // Clock cycles per millisecond tick.
    function automatic int ms_div(input int clk_freq_hz);
        return clk_freq_hz / 1000;
    endfunction

    // Width of a down-counter that holds values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/taxi_led_status_ctrl_if.sv
// Status-LED bundle: port status inputs, LED pins and per-channel FSM state for observation.
interface taxi_led_status_ctrl_if #(
    parameter int CH_CNT = 2
);
    // No valid/ready handshake: link_up/fault are levels, act is a 1-cycle pulse,
    // all synchronous to clk; pins follow one cycle after the inputs that change them.
    logic [CH_CNT-1:0]      link_up;
    logic [CH_CNT-1:0]      act;
    logic [CH_CNT-1:0]      fault;
    logic                   lamp_test;
    logic [CH_CNT-1:0]      led_link;
    logic                   led_hb;
    logic [CH_CNT-1:0][2:0] dbg_state;

    modport master (
        output link_up, act, fault, lamp_test,
        input  led_link, led_hb, dbg_state
    );

    modport slave (
        input  link_up, act, fault, lamp_test,
        output led_link, led_hb, dbg_state
    );

endinterface

// File: rtl/taxi_led_status_ch.sv
// One port LED channel: link/activity/fault FSM, blink timer and one-deep pending flag.
module taxi_led_status_ch
    import taxi_led_status_pkg::*;
#(
    parameter int BLINK_MS = 50
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_i,
    input  logic      fault_phase_i,
    input  logic      link_up_i,
    input  logic      act_i,
    input  logic      fault_i,
    output logic      led_on_o,
    output ch_state_t state_o
);

    localparam int TW = $clog2(BLINK_MS + 1);

    ch_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_dec;
    logic          pending_q, pending_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        timer_dec = timer_q - TW'(1);
        if (fault_i) begin
            state_d   = ST_FAULT;
            pending_d = 1'b0;
        end else if (!link_up_i) begin
            state_d   = ST_DOWN;
            pending_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_DOWN: state_d = ST_UP;
                ST_UP: begin
                    if (act_i) begin
                        state_d = ST_ACT_OFF;
                        timer_d = TW'(BLINK_MS);
                    end
                end
                ST_ACT_OFF: begin
                    if (act_i) pending_d = 1'b1;
                    if (tick_i) begin
                        timer_d = timer_dec;
                        if (timer_dec == '0) begin
                            state_d = ST_ACT_ON;
                            timer_d = TW'(BLINK_MS);
                        end
                    end
                end
                ST_ACT_ON: begin
                    if (act_i) pending_d = 1'b1;
                    if (tick_i) begin
                        timer_d = timer_dec;
                        if (timer_dec == '0) begin
                            // A pulse arriving on the final cycle still earns its blink.
                            if (pending_q || act_i) begin
                                state_d   = ST_ACT_OFF;
                                timer_d   = TW'(BLINK_MS);
                                pending_d = 1'b0;
                            end else begin
                                state_d = ST_UP;
                            end
                        end
                    end
                end
                ST_FAULT: state_d = ST_DOWN;
                default:  state_d = ST_DOWN;
            endcase
        end
    end

    // Decoded from the next state so the registered pin lands with the state change.
    always_comb begin
        led_on_o = 1'b0;
        unique case (state_d)
            ST_UP, ST_ACT_ON: led_on_o = 1'b1;
            ST_FAULT:         led_on_o = fault_phase_i;
            default:          led_on_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_DOWN;
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/taxi_led_status_ctrl.sv
// Board status-LED controller: ms prescaler, heartbeat, shared fault phase and pin registers.
// Optional lamp test is built only when LED_STATUS_LAMP_TEST_EN is defined.
module taxi_led_status_ctrl
    import taxi_led_status_pkg::*;
#(
    parameter int   CLK_FREQ_HZ    = 125000000,
    parameter int   CH_CNT         = 2,
    parameter int   HB_PERIOD_MS   = 1000,
    parameter int   BLINK_MS       = 50,
    parameter int   FAULT_MS       = 125,
    parameter logic LED_ACTIVE_LOW = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    taxi_led_status_ctrl_if.slave  bus
);

    localparam int DIV     = ms_div(CLK_FREQ_HZ);
    localparam int PW      = cnt_w(DIV);
    localparam int HB_HALF = HB_PERIOD_MS / 2;
    localparam int HW      = cnt_w(HB_HALF);
    localparam int FW      = cnt_w(FAULT_MS);

    if (DIV < 2) begin : g_div_chk
        $error("taxi_led_status_ctrl: CLK_FREQ_HZ/1000 must be at least 2");
    end

    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick;
    logic [HW-1:0]          hb_cnt_q, hb_cnt_d;
    logic                   hb_q, hb_d;
    logic [FW-1:0]          fault_cnt_q, fault_cnt_d;
    logic                   fault_phase_q, fault_phase_d;
    logic [CH_CNT-1:0]      ch_on;
    logic [CH_CNT-1:0]      led_link_q, led_link_d;
    logic                   led_hb_q, led_hb_d;
    logic                   lamp;
    logic [CH_CNT-1:0][2:0] dbg_state;

    assign tick = (presc_q == '0);

    always_comb begin
        presc_d       = presc_q - PW'(1);
        hb_cnt_d      = hb_cnt_q;
        hb_d          = hb_q;
        fault_cnt_d   = fault_cnt_q;
        fault_phase_d = fault_phase_q;
        if (tick) begin
            presc_d = PW'(DIV - 1);
            if (hb_cnt_q == '0) begin
                hb_cnt_d = HW'(HB_HALF - 1);
                hb_d     = ~hb_q;
            end else begin
                hb_cnt_d = hb_cnt_q - HW'(1);
            end
            if (fault_cnt_q == '0) begin
                fault_cnt_d   = FW'(FAULT_MS - 1);
                fault_phase_d = ~fault_phase_q;
            end else begin
                fault_cnt_d = fault_cnt_q - FW'(1);
            end
        end
    end

    for (genvar i = 0; i < CH_CNT; i++) begin : g_ch
        ch_state_t st;
        taxi_led_status_ch #(
            .BLINK_MS (BLINK_MS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick_i        (tick),
            .fault_phase_i (fault_phase_d),
            .link_up_i     (bus.link_up[i]),
            .act_i         (bus.act[i]),
            .fault_i       (bus.fault[i]),
            .led_on_o      (ch_on[i]),
            .state_o       (st)
        );
        assign dbg_state[i] = st;
    end

`ifdef LED_STATUS_LAMP_TEST_EN
    assign lamp = bus.lamp_test;
`else
    wire unused_lamp_test = bus.lamp_test;
    assign lamp = 1'b0;
`endif

    // Lamp test overrides only the pins; counters and FSMs keep their own time.
    assign led_link_d = (ch_on | {CH_CNT{lamp}}) ^ {CH_CNT{LED_ACTIVE_LOW}};
    assign led_hb_d   = (hb_d | lamp) ^ LED_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= PW'(DIV - 1);
            hb_cnt_q      <= HW'(HB_HALF - 1);
            hb_q          <= 1'b0;
            fault_cnt_q   <= FW'(FAULT_MS - 1);
            fault_phase_q <= 1'b0;
            led_link_q    <= {CH_CNT{LED_ACTIVE_LOW}};
            led_hb_q      <= LED_ACTIVE_LOW;
        end else begin
            presc_q       <= presc_d;
            hb_cnt_q      <= hb_cnt_d;
            hb_q          <= hb_d;
            fault_cnt_q   <= fault_cnt_d;
            fault_phase_q <= fault_phase_d;
            led_link_q    <= led_link_d;
            led_hb_q      <= led_hb_d;
        end
    end

    assign bus.led_link  = led_link_q;
    assign bus.led_hb    = led_hb_q;
    assign bus.dbg_state = dbg_state;

endmodule
